microsequencer: RTL
===================

Name: microsequencer

Overview:
- Control-unit next-state engine for the ARM simulator datapath.
- Sits directly downstream of the instruction encoder: consumes its 7-bit start-state code and the condition field of the IR.
- Also consumes next-state control fields from the control ROM and the MOC handshake from memory.
- Holds the current microstate register that addresses the control ROM.

Parameters:
- STATE_W, 7, microstate width; must equal encoder output width.
- FETCH_STATE, 1, first microstate of instruction fetch.
- ABORT_STATE, 127, microstate entered on memory timeout.
- MOC_TIMEOUT, 15, maximum cycles spent waiting for MOC before abort.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- encoder_in  in  7  start microstate from the instruction encoder (0 = null instruction).
- ir_cond  in  4  IR[31:28] condition field.
- flags  in  4  {N,Z,C,V} from the status register.
- ns_ctl  in  3  next-state control from the control ROM.
- ns_target  in  7  jump target from the control ROM.
- test_sel  in  2  test-input select for conditional jump: 0=cond_pass, 1=MOC, 2=Z, 3=const 1.
- test_inv  in  1  inverts the selected test.
- moc  in  1  memory operation complete.
- state  out  7  current microstate.
- cond_pass  out  1  combinational ARM condition result.
- mem_fault  out  1  sticky memory-timeout flag.
- ill_ctl  out  1  sticky illegal-ns_ctl flag.

Behaviour:
- Reset (async, reset_n=0): state=0, mem_fault=0, ill_ctl=0, wait counter=0.
- On the first clock edge after release, state 0 always transitions to FETCH_STATE, regardless of ns_ctl.
- All transitions take effect on the rising clk edge: one cycle per microstate. ns_ctl and ns_target are the control-ROM outputs for the current state.
- cond_pass decode (standard ARM):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; NV(1111) 0.
- ns_ctl encoding:
  - 000 INC: state+1. 127 wraps to 0, and the next cycle proceeds to FETCH.
  - 001 JUMP: ns_target.
  - 010 DECODE:
    - cond_pass=0: FETCH_STATE.
    - cond_pass=1, encoder_in=0: FETCH_STATE.
    - otherwise: encoder_in.
  - 011 WAIT_MOC:
    - moc=1: state+1; wait counter cleared.
    - moc=0: hold state; counter increments.
    - moc=0 with counter==MOC_TIMEOUT-1: state=ABORT_STATE, mem_fault set, counter cleared.
    - moc=1 in the same cycle as the timeout: moc wins.
  - 100 CJUMP: if (selected test XOR test_inv) then ns_target, else state+1.
  - 101 HOLD: stay in the current state.
  - 110 / 111 illegal: state=0, ill_ctl set.
- Wait counter:
  - Width = clog2(MOC_TIMEOUT+1).
  - Cleared whenever ns_ctl≠WAIT_MOC.
  - Saturates; never wraps.
- mem_fault and ill_ctl: sticky until reset.
- Reset mid-WAIT_MOC: state, counter and flags clear immediately; no partial transition.

Decomposition:
- Shared package ctrl_pkg: ns_ctl encodings (NS_INC…NS_HOLD), test_sel encodings, ARM condition-code constants, FETCH_STATE / ABORT_STATE defaults.
- Sub-module cond_eval: purely combinational (ir_cond, flags) -> cond_pass; reusable by the datapath.
- Everything else inline.

Test Plan:
1. Reset, then release with ns_ctl=INC -> state 0, then 1, then 2 on successive edges; all flags 0.
2. Condition-failed decode: state=1, ns_ctl=DECODE, ir_cond=0000 (EQ), flags=0000, encoder_in=7'd44 -> next state=1.
3. Condition-passed decode: same stimulus as 2 but flags=0100 -> next state=44.
4. Timeout: ns_ctl=WAIT_MOC held, moc=0 for 15 cycles -> state holds 14 cycles, then state=127, mem_fault=1.
5. Late MOC: as 4 but moc=1 on cycle 15 -> state+1, mem_fault=0.
6. CJUMP and illegal code: test_sel=2, test_inv=1, Z=0, ns_target=7'd38 -> state=38. Then ns_ctl=111 -> state=0, ill_ctl=1. Assert reset_n low mid-sequence -> state=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-unit encodings: next-state control, test select, ARM conditions.
package ctrl_pkg;

    localparam int unsigned STATE_W_DEF     = 7;
    localparam int unsigned FETCH_STATE_DEF = 1;
    localparam int unsigned ABORT_STATE_DEF = 127;
    localparam int unsigned MOC_TIMEOUT_DEF = 15;

    localparam int unsigned NS_CTL_W   = 3;
    localparam int unsigned TEST_SEL_W = 2;
    localparam int unsigned COND_W     = 4;
    localparam int unsigned FLAGS_W    = 4;

    // Next-state control field from the control ROM
    typedef enum logic [NS_CTL_W-1:0] {
        NS_INC      = 3'b000,
        NS_JUMP     = 3'b001,
        NS_DECODE   = 3'b010,
        NS_WAIT_MOC = 3'b011,
        NS_CJUMP    = 3'b100,
        NS_HOLD     = 3'b101
    } ns_ctl_e;

    // Test input for conditional jumps
    typedef enum logic [TEST_SEL_W-1:0] {
        TS_COND = 2'd0,
        TS_MOC  = 2'd1,
        TS_Z    = 2'd2,
        TS_ONE  = 2'd3
    } test_sel_e;

    // ARM condition codes (IR[31:28])
    typedef enum logic [COND_W-1:0] {
        CC_EQ = 4'b0000,
        CC_NE = 4'b0001,
        CC_CS = 4'b0010,
        CC_CC = 4'b0011,
        CC_MI = 4'b0100,
        CC_PL = 4'b0101,
        CC_VS = 4'b0110,
        CC_VC = 4'b0111,
        CC_HI = 4'b1000,
        CC_LS = 4'b1001,
        CC_GE = 4'b1010,
        CC_LT = 4'b1011,
        CC_GT = 4'b1100,
        CC_LE = 4'b1101,
        CC_AL = 4'b1110,
        CC_NV = 4'b1111
    } cond_e;

    // Bit positions of {N,Z,C,V} within the flags vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// ARM condition-code evaluator; purely combinational so the datapath can share it.
module cond_eval
    import ctrl_pkg::*;
(
    input  logic [COND_W-1:0]  ir_cond,
    input  logic [FLAGS_W-1:0] flags,
    output logic               cond_pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Standard ARM condition decode; NV never executes
    always_comb begin
        cond_pass = 1'b0;
        case (ir_cond)
            CC_EQ:   cond_pass = z;
            CC_NE:   cond_pass = ~z;
            CC_CS:   cond_pass = c;
            CC_CC:   cond_pass = ~c;
            CC_MI:   cond_pass = n;
            CC_PL:   cond_pass = ~n;
            CC_VS:   cond_pass = v;
            CC_VC:   cond_pass = ~v;
            CC_HI:   cond_pass = c & ~z;
            CC_LS:   cond_pass = ~c | z;
            CC_GE:   cond_pass = (n == v);
            CC_LT:   cond_pass = (n != v);
            CC_GT:   cond_pass = ~z & (n == v);
            CC_LE:   cond_pass = z | (n != v);
            CC_AL:   cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/microsequencer.sv
// Control-unit next-state engine: holds the microstate that addresses the control ROM.
module microsequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned STATE_W     = STATE_W_DEF,
    parameter int unsigned FETCH_STATE = FETCH_STATE_DEF,
    parameter int unsigned ABORT_STATE = ABORT_STATE_DEF,
    parameter int unsigned MOC_TIMEOUT = MOC_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [STATE_W-1:0]    encoder_in,
    input  logic [COND_W-1:0]     ir_cond,
    input  logic [FLAGS_W-1:0]    flags,
    input  logic [NS_CTL_W-1:0]   ns_ctl,
    input  logic [STATE_W-1:0]    ns_target,
    input  logic [TEST_SEL_W-1:0] test_sel,
    input  logic                  test_inv,
    input  logic                  moc,
    output logic [STATE_W-1:0]    state,
    output logic                  cond_pass,
    output logic                  mem_fault,
    output logic                  ill_ctl
);

    localparam int unsigned CNT_W = $clog2(MOC_TIMEOUT + 1);

    localparam logic [STATE_W-1:0] FETCH     = STATE_W'(FETCH_STATE);
    localparam logic [STATE_W-1:0] ABORT     = STATE_W'(ABORT_STATE);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(MOC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               mem_fault_q, mem_fault_d;
    logic               ill_ctl_q, ill_ctl_d;
    logic [STATE_W-1:0] state_inc;
    logic               test_raw;
    logic               test_hit;

    cond_eval u_cond_eval (
        .ir_cond   (ir_cond),
        .flags     (flags),
        .cond_pass (cond_pass)
    );

    assign state_inc = state_q + STATE_W'(1);

    // Conditional-jump test mux, optionally inverted
    always_comb begin
        test_raw = 1'b0;
        case (test_sel)
            TS_COND: test_raw = cond_pass;
            TS_MOC:  test_raw = moc;
            TS_Z:    test_raw = flags[FLAG_Z];
            default: test_raw = 1'b1;
        endcase
        test_hit = test_raw ^ test_inv;
    end

    // State, wait counter and sticky flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= '0;
            wait_cnt_q  <= '0;
            mem_fault_q <= 1'b0;
            ill_ctl_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_fault_q <= mem_fault_d;
            ill_ctl_q   <= ill_ctl_d;
        end
    end

    // Next-state selection; microstate 0 always boots into fetch
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        mem_fault_d = mem_fault_q;
        ill_ctl_d   = ill_ctl_q;

        if (state_q == '0) begin
            state_d = FETCH;
        end else begin
            case (ns_ctl)
                NS_INC:  state_d = state_inc;
                NS_JUMP: state_d = ns_target;
                NS_DECODE: begin
                    if (cond_pass && (encoder_in != '0)) state_d = encoder_in;
                    else                                 state_d = FETCH;
                end
                NS_WAIT_MOC: begin
                    if (moc) begin
                        state_d = state_inc;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        state_d     = ABORT;
                        mem_fault_d = 1'b1;
                    end else begin
                        wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q
                                                             : wait_cnt_q + CNT_W'(1);
                    end
                end
                NS_CJUMP: state_d = test_hit ? ns_target : state_inc;
                NS_HOLD:  state_d = state_q;
                default: begin
                    state_d   = '0;
                    ill_ctl_d = 1'b1;
                end
            endcase
        end
    end

    assign state     = state_q;
    assign mem_fault = mem_fault_q;
    assign ill_ctl   = ill_ctl_q;

endmodule
